// File: rtl/mul_div_unit_if.sv
// Execute-stage multiply/divide port bundle: issue strobes, operands and HI/LO results.
interface mul_div_unit_if;
    logic        StartE;
    logic [1:0]  MdOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        MthiE;
    logic        MtloE;
    logic        MdUseD;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        BusyMD;
    logic        StallMD;
    logic        DoneMD;

    // Pipeline side: issues operations and reads HI/LO.
    modport master (
        output StartE, MdOpE, SrcAE, SrcBE, MthiE, MtloE, MdUseD,
        input  HI, LO, BusyMD, StallMD, DoneMD
    );

    // Unit side.
    modport slave (
        input  StartE, MdOpE, SrcAE, SrcBE, MthiE, MtloE, MdUseD,
        output HI, LO, BusyMD, StallMD, DoneMD
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shared 64-bit accumulator: {partial, multiplier} for multiply,
// {remainder, dividend/quotient} for restoring divide.
module mul_div_unit (
    input  logic           clk,
    input  logic           reset_n,
    mul_div_unit_if.slave  md_if
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [2*DW-1:0] r_acc, w_acc_nxt;
    logic [DW-1:0]   r_b, w_b_nxt;
    logic            r_sign_a, w_sign_a_nxt;
    logic            r_sign_b, w_sign_b_nxt;
    logic            r_is_div, w_is_div_nxt;
    logic [DW-1:0]   r_hi, w_hi_nxt;
    logic [DW-1:0]   r_lo, w_lo_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;

    logic            w_signed_op;
    logic [DW-1:0]   w_mag_a, w_mag_b;
    logic [DW:0]     w_mul_sum;
    logic [2*DW-1:0] w_mul_step;
    logic [DW:0]     w_div_trial;
    logic [2*DW-1:0] w_div_step;
    logic            w_neg;
    logic [2*DW-1:0] w_prod;
    logic [DW-1:0]   w_quot, w_rem;

    // Operand magnitudes for the signed ops (MULT/DIV have MdOpE[0]=0).
    assign w_signed_op = ~md_if.MdOpE[0];
    assign w_mag_a = (w_signed_op && md_if.SrcAE[DW-1]) ? DW'(-md_if.SrcAE) : md_if.SrcAE;
    assign w_mag_b = (w_signed_op && md_if.SrcBE[DW-1]) ? DW'(-md_if.SrcBE) : md_if.SrcBE;

    // One radix-2 shift-add multiply step.
    assign w_mul_sum  = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_b} : (DW+1)'(0));
    assign w_mul_step = {w_mul_sum, r_acc[DW-1:1]};

    // One restoring divide step: trial-subtract the shifted partial remainder.
    assign w_div_trial = r_acc[2*DW-1:DW-1] - {1'b0, r_b};
    assign w_div_step  = w_div_trial[DW] ? {r_acc[2*DW-2:0], 1'b0}
                                         : {w_div_trial[DW-1:0], r_acc[DW-2:0], 1'b1};

    // Sign correction; signs are only captured as set for signed ops.
    assign w_neg  = r_sign_a ^ r_sign_b;
    assign w_prod = w_neg ? (2*DW)'(-r_acc) : r_acc;
    assign w_quot = w_neg ? DW'(-r_acc[DW-1:0]) : r_acc[DW-1:0];
    assign w_rem  = r_sign_a ? DW'(-r_acc[2*DW-1:DW]) : r_acc[2*DW-1:DW];

    // Next-state and datapath/output next values.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_b_nxt      = r_b;
        w_sign_a_nxt = r_sign_a;
        w_sign_b_nxt = r_sign_b;
        w_is_div_nxt = r_is_div;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (md_if.StartE) begin
                    w_acc_nxt    = {DW'(0), w_mag_a};
                    w_b_nxt      = w_mag_b;
                    w_sign_a_nxt = w_signed_op & md_if.SrcAE[DW-1];
                    w_sign_b_nxt = w_signed_op & md_if.SrcBE[DW-1];
                    w_is_div_nxt = md_if.MdOpE[1];
                    w_cnt_nxt    = CW'(0);
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = S_CALC;
                end else begin
                    if (md_if.MthiE) w_hi_nxt = md_if.SrcAE;
                    if (md_if.MtloE) w_lo_nxt = md_if.SrcAE;
                end
            end
            S_CALC: begin
                w_acc_nxt = r_is_div ? w_div_step : w_mul_step;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(31)) w_state_nxt = S_FIX;
            end
            S_FIX: begin
                if (!r_is_div) begin
                    w_hi_nxt = w_prod[2*DW-1:DW];
                    w_lo_nxt = w_prod[DW-1:0];
                end else if (r_b == DW'(0)) begin
                    // Divide by zero: raw all-ones quotient, HI restores the dividend.
                    w_lo_nxt = '1;
                    w_hi_nxt = w_rem;
                end else begin
                    w_lo_nxt = w_quot;
                    w_hi_nxt = w_rem;
                end
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_b      <= w_b_nxt;
            r_sign_a <= w_sign_a_nxt;
            r_sign_b <= w_sign_b_nxt;
            r_is_div <= w_is_div_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign md_if.HI      = r_hi;
    assign md_if.LO      = r_lo;
    assign md_if.BusyMD  = r_busy;
    assign md_if.DoneMD  = r_done;
    // Hazard-unit stall request; drops in the cycle the result lands.
    assign md_if.StallMD = md_if.MdUseD & r_busy;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops vs. an arithmetic model.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic reset_n;
    int   n_pass  = 0;
    int   n_total = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mul_div_unit_if md();

    mul_div_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md_if   (md)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result computed with plain integer arithmetic.
    function automatic void ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
            2'b01: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (op == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    lo = sq[31:0];
                    hi = sr[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Issue one operation and check latency, busy/stall timing and result.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit use_d, input bit inject, input string tag);
        logic [31:0] eh, el;
        int          busy_cnt, done_cyc;
        bit          stall_ok;
        ref_md(op, a, b, eh, el);
        md.StartE = 1'b1;
        md.MdOpE  = op;
        md.SrcAE  = a;
        md.SrcBE  = b;
        md.MdUseD = use_d;
        busy_cnt  = 0;
        done_cyc  = 0;
        stall_ok  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            md.StartE = 1'b0;
            md.MthiE  = 1'b0;
            md.MtloE  = 1'b0;
            if (inject && c == 5) begin
                md.StartE = 1'b1;
                md.MdOpE  = ~op;
                md.SrcAE  = $urandom;
                md.SrcBE  = $urandom;
                md.MthiE  = 1'b1;
                md.MtloE  = 1'b1;
            end
            if (inject && c == 7) begin
                check({tag, " hi_held_busy"}, 64'(md.HI), 64'(m_hi));
                check({tag, " lo_held_busy"}, 64'(md.LO), 64'(m_lo));
            end
            if (md.BusyMD === 1'b1) busy_cnt++;
            if (md.StallMD !== ((use_d && c <= 33) ? 1'b1 : 1'b0)) stall_ok = 1'b0;
            if (md.DoneMD === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
        m_hi = eh;
        m_lo = el;
        check({tag, " done_cycle"}, 64'(done_cyc), 64'd34);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, " stall"}, 64'(stall_ok), 64'd1);
        check({tag, " hi"}, 64'(md.HI), 64'(eh));
        check({tag, " lo"}, 64'(md.LO), 64'(el));
        step();
        check({tag, " done_pulse"}, 64'(md.DoneMD), 64'd0);
        md.MdUseD = 1'b0;
    endtask

    // MTHI/MTLO write from IDLE.
    task automatic move_to(input bit wh, input bit wl, input logic [31:0] v, input string tag);
        md.MthiE = wh;
        md.MtloE = wl;
        md.SrcAE = v;
        step();
        md.MthiE = 1'b0;
        md.MtloE = 1'b0;
        if (wh) m_hi = v;
        if (wl) m_lo = v;
        check({tag, " hi"}, 64'(md.HI), 64'(m_hi));
        check({tag, " lo"}, 64'(md.LO), 64'(m_lo));
    endtask

    initial begin
        bit          seen_done, seen_busy;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        reset_n   = 1'b0;
        md.StartE = 1'b0;
        md.MdOpE  = 2'b00;
        md.SrcAE  = '0;
        md.SrcBE  = '0;
        md.MthiE  = 1'b0;
        md.MtloE  = 1'b0;
        md.MdUseD = 1'b1;
        #12;
        check("rst hi", 64'(md.HI), 64'd0);
        check("rst lo", 64'(md.LO), 64'd0);
        check("rst busy", 64'(md.BusyMD), 64'd0);
        check("rst done", 64'(md.DoneMD), 64'd0);
        check("rst stall", 64'(md.StallMD), 64'd0);
        md.MdUseD = 1'b0;
        #10 reset_n = 1'b1;

        // First StartE right at the first edge after reset release.
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, "mult_m3x7");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div_m7d2");
        run_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0, "divu_by0");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, "div_neg_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1, "div_inject");
        move_to(1'b1, 1'b1, 32'hCAFE_F00D, "mt_both");
        move_to(1'b1, 1'b0, 32'h0BAD_BEEF, "mthi");

        // Randomized mix of ops and moves.
        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 4) == 0) rb = 32'd0;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            if ($urandom_range(0, 5) == 0) begin
                move_to(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, "rnd_mt");
            end else begin
                run_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd_op");
            end
        end

        // Reset in the middle of CALC (counter at 10) discards the operation.
        move_to(1'b1, 1'b1, 32'h5555_AAAA, "pre_rst");
        md.StartE = 1'b1;
        md.MdOpE  = 2'b01;
        md.SrcAE  = 32'h1234_5678;
        md.SrcBE  = 32'h9ABC_DEF0;
        step();
        md.StartE = 1'b0;
        repeat (10) step();
        md.MdUseD = 1'b1;
        check("midcalc busy", 64'(md.BusyMD), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("midrst hi", 64'(md.HI), 64'd0);
        check("midrst lo", 64'(md.LO), 64'd0);
        check("midrst busy", 64'(md.BusyMD), 64'd0);
        check("midrst done", 64'(md.DoneMD), 64'd0);
        check("midrst stall", 64'(md.StallMD), 64'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        md.MdUseD = 1'b0;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (40) begin
            step();
            if (md.DoneMD === 1'b1) seen_done = 1'b1;
            if (md.BusyMD === 1'b1) seen_busy = 1'b1;
        end
        check("postrst no_done", 64'(seen_done), 64'd0);
        check("postrst no_busy", 64'(seen_busy), 64'd0);
        move_to(1'b0, 1'b1, 32'h0000_1234, "mtlo_after_rst");
        run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, "mult_extreme");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 The block SHALL have one clock, clk; reset is asynchronous and active-low on reset_n.
REQ-003 clk  in  1  rising-edge clock, shared with the pipeline.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 StartE  in  1  Execute-stage MULT/MULTU/DIV/DIVU issue strobe.
REQ-006 MdOpE  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SrcAE, SrcBE  in  32 each  operands: rs and rt, already forwarded.
REQ-008 MthiE, MtloE  in  1 each  move-to-HI and move-to-LO strobes; the value is SrcAE.
REQ-009 MdUseD  in  1  Decode-stage instruction is MFHI, MFLO, MTHI, MTLO or a mul/div.
REQ-010 HI, LO  out  32 each  architectural HI/LO registers.
REQ-011 BusyMD  out  1  an operation is in progress.
REQ-012 StallMD  out  1  stall request to the hazard unit; it is ORed into StallF, StallD and FlushE.
REQ-013 DoneMD  out  1  one-cycle pulse when HI/LO take a new mul/div result.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and FIX.
REQ-015 In IDLE, StartE=1 SHALL capture the operand magnitudes, their signs and MdOpE, clear the 5-bit counter, and move to CALC at the next edge.
REQ-016 StartE SHALL be ignored outside IDLE.
REQ-017 CALC SHALL run exactly 32 cycles (counter 0..31), doing one iteration per cycle:
  - multiply: radix-2 shift-add over a 64-bit product;
  - divide: restoring shift-subtract, giving a 32-bit quotient and remainder.
REQ-018 CALC SHALL move to FIX on counter=31.
REQ-019 In FIX the block SHALL apply the sign correction, load HI/LO at the closing edge, and return to IDLE.
REQ-020 Latency: StartE high in cycle 0 -> BusyMD high in cycles 1..33 -> new HI/LO and DoneMD=1 in cycle 34.
REQ-021 Signed multiply SHALL negate the 64-bit product when signA^signB=1.
REQ-022 Multiply results SHALL be HI=product[63:32] and LO=product[31:0].
REQ-023 Divide SHALL produce LO=quotient and HI=remainder.
  - Signed: the quotient is negated when signA^signB=1; the remainder takes the sign of the dividend.
REQ-024 Divide by zero (either signedness) SHALL produce LO=32'hFFFFFFFF and HI=SrcAE with no exception.
  - Signed case: LO is the raw 32'hFFFFFFFF, never sign-corrected.
REQ-025 Signed DIV of 32'h80000000 by 32'hFFFFFFFF SHALL produce LO=32'h80000000 and HI=0.
REQ-026 MthiE/MtloE SHALL update HI/LO at the next edge only while in IDLE with StartE=0; otherwise they are ignored.
REQ-027 With MthiE and MtloE both high, both registers SHALL be written.
REQ-028 StallMD SHALL equal MdUseD & BusyMD, combinationally.
  - StallMD is therefore deasserted in cycle 34, so a dependent MFHI/MFLO proceeds and reads the new HI/LO.
REQ-029 Outside FIX and MTHI/MTLO writes, HI/LO SHALL hold their value.
REQ-030 BusyMD SHALL be high in CALC and FIX only.
REQ-031 DoneMD SHALL be a registered pulse, high for exactly one cycle per completed operation.

Reset
REQ-032 reset_n=0 SHALL asynchronously force the following, regardless of the current state, including mid-CALC:
  - state=IDLE and counter=0;
  - HI=0 and LO=0;
  - BusyMD=0, DoneMD=0 and StallMD=0.
REQ-033 A reset during an operation SHALL discard the operation; it SHALL not resume after reset_n rises.
REQ-034 The first StartE SHALL be accepted at the first rising edge after reset_n deasserts.

Verification
REQ-035 MULTU: 32'hFFFFFFFF x 32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001, with DoneMD in cycle 34.
REQ-036 MULT: -3 x 7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; BusyMD high for exactly 33 cycles.
REQ-037 DIV: -7 / 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU: 7 / 0 -> LO=32'hFFFFFFFF, HI=7.
REQ-038 Stall handling:
  - MdUseD=1 held during an operation -> StallMD=1 in cycles 1..33 and 0 in cycle 34.
  - A second StartE during CALC is ignored; HI/LO reflect only the first operation.
REQ-039 reset_n pulsed low at CALC count 10 -> HI=LO=0, BusyMD=0 immediately, no DoneMD.
  - After reset_n rises, MTLO 32'h1234 in IDLE -> LO=32'h1234 at the next edge.
